// File: rtl/count_seq_ctrl.sv
// Counter-chain sequencer: debounces three push-buttons, runs a STOP/RUN/CLEAR/LOAD
// FSM and issues prescaled count enables, direction, clear and load strobes to a BCD chain.
module count_seq_ctrl #(
    parameter int PRESCALE_W = 20,
    parameter int DEBOUNCE_W = 16,
    parameter int AUTO_STOP  = 0
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        btn_run,
    input  logic        btn_dir,
    input  logic        btn_clr,
    input  logic        load_req,
    input  logic [15:0] load_val,
    input  logic [3:0]  tc,
    output logic        ce,
    output logic        up,
    output logic        clr,
    output logic        load,
    output logic [15:0] load_data,
    output logic [2:0]  led_n
);

    localparam int NUM_BTN = 3;
    localparam int BTN_RUN = 0;
    localparam int BTN_DIR = 1;
    localparam int BTN_CLR = 2;

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CLEAR = 2'd2,
        ST_LOAD  = 2'd3
    } state_t;

    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] press;

    assign btn_raw = {btn_clr, btn_dir, btn_run};

    // Per button: 2-FF synchronizer, stability counter, rising-edge press pulse.
    // The press pulse is registered so it lines up with the new debounced level.
    generate
        for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
            logic                  sync1_reg;
            logic                  sync2_reg;
            logic                  level_reg;
            logic                  press_reg;
            logic [DEBOUNCE_W-1:0] cnt_reg;

            always_ff @(posedge sys_clk or posedge sys_rst) begin
                if (sys_rst) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                    level_reg <= 1'b0;
                    press_reg <= 1'b0;
                    cnt_reg   <= '0;
                end else begin
                    sync1_reg <= btn_raw[gi];
                    sync2_reg <= sync1_reg;
                    press_reg <= 1'b0;
                    if (sync2_reg == level_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == '1) begin
                        level_reg <= sync2_reg;
                        press_reg <= sync2_reg;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + DEBOUNCE_W'(1);
                    end
                end
            end

            assign press[gi] = press_reg;
        end
    endgenerate

    logic run_press;
    logic dir_press;
    logic clr_press;

    assign run_press = press[BTN_RUN];
    assign dir_press = press[BTN_DIR];
    assign clr_press = press[BTN_CLR];

    state_t                state_reg, state_next;
    logic [PRESCALE_W-1:0] presc_reg, presc_next;
    logic                  up_reg, up_next;
    logic                  wrap_reg, wrap_next;
    logic [15:0]           load_data_reg, load_data_next;
    logic [2:0]            led_n_reg, led_n_next;
    logic                  ce_next;
    logic                  ce_due;
    logic                  wrap_hit;

    assign ce_due = (state_reg == ST_RUN) && (presc_reg == '1);

    always_comb begin
        state_next     = state_reg;
        presc_next     = '0;
        up_next        = up_reg ^ dir_press;
        wrap_next      = wrap_reg;
        load_data_next = load_data_reg;
        ce_next        = 1'b0;
        wrap_hit       = 1'b0;

        // Any exit from RUN in a ce-due cycle swallows that ce.
        if (clr_press) begin
            state_next = ST_CLEAR;
        end else begin
            case (state_reg)
                ST_STOP: begin
                    if (load_req) begin
                        load_data_next = load_val;
                        state_next     = ST_LOAD;
                    end else if (run_press) begin
                        state_next = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (run_press) begin
                        state_next = ST_STOP;
                    end else if (ce_due) begin
                        if (tc == 4'b1111) begin
                            wrap_hit = 1'b1;
                            if (AUTO_STOP != 0) begin
                                state_next = ST_STOP;
                            end else begin
                                ce_next = 1'b1;
                            end
                        end else begin
                            ce_next = 1'b1;
                        end
                    end
                end
                ST_CLEAR: state_next = ST_STOP;
                ST_LOAD:  state_next = ST_STOP;
                default:  state_next = ST_STOP;
            endcase
        end

        if (wrap_hit) begin
            wrap_next = 1'b1;
        end
        if (state_reg == ST_CLEAR) begin
            wrap_next = 1'b0;
        end

        if ((state_reg == ST_RUN) && (state_next == ST_RUN)) begin
            presc_next = presc_reg + PRESCALE_W'(1);
        end

        // Built from next-state values so the LEDs change on the same edge as the state.
        led_n_next = {~wrap_next, up_next, ~(state_next == ST_RUN)};
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_reg     <= ST_STOP;
            presc_reg     <= '0;
            up_reg        <= 1'b1;
            wrap_reg      <= 1'b0;
            load_data_reg <= 16'h0000;
            led_n_reg     <= 3'b111;
        end else begin
            state_reg     <= state_next;
            presc_reg     <= presc_next;
            up_reg        <= up_next;
            wrap_reg      <= wrap_next;
            load_data_reg <= load_data_next;
            led_n_reg     <= led_n_next;
        end
    end

    assign ce        = ce_next;
    assign up        = up_reg;
    assign clr       = (state_reg == ST_CLEAR);
    assign load      = (state_reg == ST_LOAD);
    assign load_data = load_data_reg;
    assign led_n     = led_n_reg;

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Directed bench for count_seq_ctrl: one instance wraps (AUTO_STOP=0), one stops (AUTO_STOP=1).
`timescale 1ns/1ps
module tb_count_seq_ctrl;

    localparam int PW = 3;
    localparam int DW = 2;

    logic        clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        btn_run = 1'b0;
    logic        btn_dir = 1'b0;
    logic        btn_clr = 1'b0;
    logic        load_req = 1'b0;
    logic [15:0] load_val = 16'h0000;
    logic [3:0]  tc = 4'h0;

    logic        ce0, up0, clr0, load0, ce1, up1, clr1, load1;
    logic [15:0] ld0, ld1;
    logic [2:0]  led0, led1;

    int vec_count = 0;
    int err_count = 0;
    int k = -1;

    always #5 clk = ~clk;

    count_seq_ctrl #(.PRESCALE_W(PW), .DEBOUNCE_W(DW), .AUTO_STOP(0)) dut0 (
        .sys_clk(clk), .sys_rst(sys_rst), .btn_run(btn_run), .btn_dir(btn_dir),
        .btn_clr(btn_clr), .load_req(load_req), .load_val(load_val), .tc(tc),
        .ce(ce0), .up(up0), .clr(clr0), .load(load0), .load_data(ld0), .led_n(led0)
    );

    count_seq_ctrl #(.PRESCALE_W(PW), .DEBOUNCE_W(DW), .AUTO_STOP(1)) dut1 (
        .sys_clk(clk), .sys_rst(sys_rst), .btn_run(btn_run), .btn_dir(btn_dir),
        .btn_clr(btn_clr), .load_req(load_req), .load_val(load_val), .tc(tc),
        .ce(ce1), .up(up1), .clr(clr1), .load(load1), .load_data(ld1), .led_n(led1)
    );

    typedef struct {
        logic        lr;
        logic [15:0] val;
        logic        exp_load;
        logic [15:0] exp_data;
        logic [2:0]  exp_led;
    } vec_t;

    vec_t tbl [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_count++;
        if (act !== exp) begin
            err_count++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end else begin
            $display("ok   %s value=%0h", name, act);
        end
    endtask

    // One clock; k counts cycles spent in RUN on dut0, starting at 0.
    task automatic tick();
        @(posedge clk);
        #1;
        if (led0[0] == 1'b0) k = k + 1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ce0"},   32'(ce0),   32'd0);
        check({tag, "_clr0"},  32'(clr0),  32'd0);
        check({tag, "_load0"}, 32'(load0), 32'd0);
        check({tag, "_ld0"},   32'(ld0),   32'h0000);
        check({tag, "_led0"},  32'(led0),  32'b111);
        check({tag, "_up0"},   32'(up0),   32'd1);
        check({tag, "_led1"},  32'(led1),  32'b111);
        check({tag, "_ce1"},   32'(ce1),   32'd0);
    endtask

    initial begin
        int entries;
        logic was_run;

        tbl[0] = '{lr: 1'b1, val: 16'h1234, exp_load: 1'b1, exp_data: 16'h1234, exp_led: 3'b111};
        tbl[1] = '{lr: 1'b1, val: 16'h5678, exp_load: 1'b0, exp_data: 16'h1234, exp_led: 3'b111};
        tbl[2] = '{lr: 1'b0, val: 16'h9999, exp_load: 1'b0, exp_data: 16'h1234, exp_led: 3'b111};
        tbl[3] = '{lr: 1'b1, val: 16'h0000, exp_load: 1'b1, exp_data: 16'h0000, exp_led: 3'b111};
        tbl[4] = '{lr: 1'b0, val: 16'h4321, exp_load: 1'b0, exp_data: 16'h0000, exp_led: 3'b111};

        // Reset values while held and just after release
        repeat (3) @(posedge clk);
        #1;
        check_idle("rst_held");
        @(negedge clk);
        sys_rst = 1'b0;
        tick();
        check_idle("rst_rel");

        // Load vectors applied in STOP; second request lands in LOAD and is ignored
        for (int i = 0; i < 5; i++) begin
            load_req = tbl[i].lr;
            load_val = tbl[i].val;
            tick();
            check($sformatf("load_v%0d_load", i), 32'(load0), 32'(tbl[i].exp_load));
            check($sformatf("load_v%0d_data", i), 32'(ld0),   32'(tbl[i].exp_data));
            check($sformatf("load_v%0d_led", i),  32'(led0),  32'(tbl[i].exp_led));
            check($sformatf("load_v%0d_data1", i), 32'(ld1),  32'(tbl[i].exp_data));
        end
        load_req = 1'b0;

        // Two-cycle glitch on btn_run must not be accepted
        btn_run = 1'b1;
        repeat (2) tick();
        btn_run = 1'b0;
        repeat (12) tick();
        check("glitch_led", 32'(led0), 32'b111);
        check("glitch_ce",  32'(ce0),  32'd0);
        check("glitch_k",   32'(k),    32'hFFFF_FFFF);

        // Hold btn_run for 10 cycles: one RUN entry, ce every 8 cycles
        entries = 0;
        was_run = 1'b0;
        btn_run = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (cyc == 10) btn_run = 1'b0;
            tick();
            if (!led0[0] && !was_run) entries++;
            was_run = !led0[0];
            if (k >= 0) begin
                check($sformatf("run_ce0_k%0d", k), 32'(ce0), 32'((k % 8) == 7));
                check($sformatf("run_ce1_k%0d", k), 32'(ce1), 32'((k % 8) == 7));
                check($sformatf("run_led0_k%0d", k), 32'(led0), 32'b110);
            end
        end
        check("run_entries", 32'(entries), 32'd1);
        check("run_led1", 32'(led1), 32'b110);

        // Wrap at ce-due: dut0 keeps running with ce, dut1 suppresses ce and stops
        while ((k % 8) != 7) tick();
        tc = 4'hF;
        #1;
        check("wrap_ce0", 32'(ce0), 32'd1);
        check("wrap_ce1", 32'(ce1), 32'd0);
        tick();
        tc = 4'h0;
        check("wrap_led0", 32'(led0), 32'b010);
        check("wrap_led1", 32'(led1), 32'b011);
        check("wrap_ce1_after", 32'(ce1), 32'd0);
        repeat (7) tick();
        check("wrap_next_ce0", 32'(ce0), 32'd1);

        // Dir press timed to land on the ce cycle (2 sync + 4 debounce cycles)
        while ((k % 8) != 1) tick();
        btn_dir = 1'b1;
        repeat (6) tick();
        check("dir_ce0", 32'(ce0), 32'd1);
        check("dir_up_at_ce", 32'(up0), 32'd1);
        tick();
        check("dir_up_after", 32'(up0), 32'd0);
        check("dir_led0", 32'(led0), 32'b000);
        check("dir_up1", 32'(up1), 32'd0);
        btn_dir = 1'b0;
        repeat (16) tick();
        check("dir_release_up", 32'(up0), 32'd0);

        // clr and run pressed together in RUN: clr wins, one CLEAR cycle, wrap cleared
        btn_clr = 1'b1;
        btn_run = 1'b1;
        repeat (7) tick();
        check("clr_strobe0", 32'(clr0), 32'd1);
        check("clr_strobe1", 32'(clr1), 32'd1);
        check("clr_ce0", 32'(ce0), 32'd0);
        tick();
        check("clr_end0", 32'(clr0), 32'd0);
        check("clr_led0", 32'(led0), 32'b101);
        check("clr_led1", 32'(led1), 32'b101);
        btn_clr = 1'b0;
        btn_run = 1'b0;
        repeat (12) tick();
        check("clr_stays_stop", 32'(led0), 32'b101);
        check("clr_no_ce", 32'(ce0), 32'd0);

        // Reset during LOAD aborts the strobe
        load_req = 1'b1;
        load_val = 16'hABCD;
        tick();
        load_req = 1'b0;
        check("rl_load", 32'(load0), 32'd1);
        check("rl_data", 32'(ld0), 32'hABCD);
        #2 sys_rst = 1'b1;
        #1;
        check_idle("rl_async");
        @(negedge clk);
        sys_rst = 1'b0;
        repeat (3) tick();
        check_idle("rl_after");

        // Reset during CLEAR aborts the strobe
        btn_clr = 1'b1;
        repeat (7) tick();
        check("rc_clr", 32'(clr0), 32'd1);
        btn_clr = 1'b0;
        #2 sys_rst = 1'b1;
        #1;
        check_idle("rc_async");
        @(negedge clk);
        sys_rst = 1'b0;
        repeat (3) tick();
        check_idle("rc_after");

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
